// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared constants and types for the 2-read/1-write register file slice.
//   DEF_WIDTH / DEF_ADDR_WIDTH : default data and address widths
//   NUM_REGS                   : entry count for the default address width
//   ZERO_ADDR                  : index of the hard-zero register
//   reg_addr_t                 : register address type (default width)
// -----------------------------------------------------------------------------
package regfile_pkg;

  localparam int DEF_WIDTH      = 32;
  localparam int DEF_ADDR_WIDTH = 5;
  localparam int NUM_REGS       = 2 ** DEF_ADDR_WIDTH;
  localparam int ZERO_ADDR      = 0;

  typedef logic [DEF_ADDR_WIDTH-1:0] reg_addr_t;

endpackage : regfile_pkg

// File: rtl/regfile_2r1w_if.sv
// -----------------------------------------------------------------------------
// regfile_2r1w_if
// Bundle between the decode/control side (master) and the register file
// (slave).
//   wrenable, write_addr, write_data : write port
//   read_addr1/2                     : read port addresses
//   claim, claim_addr                : mark a register as having a write in flight
//   read_data1/2, busy1/2            : registered read results and pending flags
// -----------------------------------------------------------------------------
interface regfile_2r1w_if
  import regfile_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);

  logic                  wrenable;
  logic [ADDR_WIDTH-1:0] write_addr;
  logic [WIDTH-1:0]      write_data;
  logic [ADDR_WIDTH-1:0] read_addr1;
  logic [ADDR_WIDTH-1:0] read_addr2;
  logic                  claim;
  logic [ADDR_WIDTH-1:0] claim_addr;
  logic [WIDTH-1:0]      read_data1;
  logic [WIDTH-1:0]      read_data2;
  logic                  busy1;
  logic                  busy2;

  modport master (
    output wrenable, write_addr, write_data,
    output read_addr1, read_addr2,
    output claim, claim_addr,
    input  read_data1, read_data2, busy1, busy2
  );

  modport slave (
    input  wrenable, write_addr, write_data,
    input  read_addr1, read_addr2,
    input  claim, claim_addr,
    output read_data1, read_data2, busy1, busy2
  );

endinterface : regfile_2r1w_if

// File: rtl/decoder_1toN.sv
// -----------------------------------------------------------------------------
// decoder_1toN
// Combinational one-hot decoder: o_sel[i_addr] = i_en, all other bits 0.
// Used for both the write-enable and the claim decoding.
//   i_en   : strobe
//   i_addr : selected index
//   o_sel  : one-hot select vector (N = 2**ADDR_WIDTH bits)
// -----------------------------------------------------------------------------
module decoder_1toN #(
  parameter int ADDR_WIDTH = 5,
  parameter int N          = 2 ** ADDR_WIDTH
) (
  input  logic                  i_en,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [N-1:0]          o_sel
);

  always_comb begin
    // NOTE: default assignment first so every path drives o_sel; no latch.
    o_sel = '0;
    if (i_en) o_sel[i_addr] = 1'b1;
  end

endmodule : decoder_1toN

// File: rtl/registerN.sv
// -----------------------------------------------------------------------------
// registerN
// One register-file entry with write enable and asynchronous active-low reset.
//   clk, rst_n : clock and reset
//   i_we, i_d  : write enable and data
//   o_q        : stored value
// -----------------------------------------------------------------------------
module registerN #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_we,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  // NOTE: every entry is reset, because a mid-run reset must discard all
  // contents and the pipeline reads registers it never wrote.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_q <= '0;
    else if (i_we) r_q <= i_d;
  end

  assign o_q = r_q;

endmodule : registerN

// File: rtl/registerNzero.sv
// -----------------------------------------------------------------------------
// registerNzero
// Hard-zero entry: holds no state and always reads 0.
//   o_q : constant zero
// -----------------------------------------------------------------------------
module registerNzero #(
  parameter int WIDTH = 32
) (
  output logic [WIDTH-1:0] o_q
);

  assign o_q = '0;

endmodule : registerNzero

// File: rtl/regfile_2r1w.sv
// -----------------------------------------------------------------------------
// regfile_2r1w
// 2**ADDR_WIDTH-entry register file: two registered read ports, one write
// port, optional same-edge write-to-read bypass and a pending-write
// scoreboard so control can stall on operands still in flight.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus (slave)  : write port, read addresses, claim, read data and busy flags
// Entry 0 ignores writes and claims and always reads 0 / not busy.
// -----------------------------------------------------------------------------
module regfile_2r1w
  import regfile_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter bit BYPASS     = 1'b1
) (
  input  logic           clk,
  input  logic           reset_n,
  regfile_2r1w_if.slave  bus
);

  localparam int          N         = 2 ** ADDR_WIDTH;
  // Clears the zero-register bit so writes/claims to it have no effect.
  localparam logic [N-1:0] ZERO_MASK = ~(N'(1) << ZERO_ADDR);

  logic [N-1:0]     w_wr_sel_raw;
  logic [N-1:0]     w_claim_sel_raw;
  logic [N-1:0]     w_wr_sel;
  logic [N-1:0]     w_claim_sel;
  logic [N-1:0]     w_pending_next;
  logic [N-1:0]     r_pending;
  logic [WIDTH-1:0] w_entry [N];

  logic             w_hit1, w_hit2;
  logic [WIDTH-1:0] w_rd1_next, w_rd2_next;
  logic             w_busy1_next, w_busy2_next;

  logic [WIDTH-1:0] r_read_data1, r_read_data2;
  logic             r_busy1, r_busy2;

  decoder_1toN #(.ADDR_WIDTH(ADDR_WIDTH), .N(N)) u_wr_dec (
    .i_en   (bus.wrenable),
    .i_addr (bus.write_addr),
    .o_sel  (w_wr_sel_raw)
  );

  decoder_1toN #(.ADDR_WIDTH(ADDR_WIDTH), .N(N)) u_claim_dec (
    .i_en   (bus.claim),
    .i_addr (bus.claim_addr),
    .o_sel  (w_claim_sel_raw)
  );

  assign w_wr_sel    = w_wr_sel_raw    & ZERO_MASK;
  assign w_claim_sel = w_claim_sel_raw & ZERO_MASK;

  for (genvar gi = 0; gi < N; gi++) begin : g_entry
    if (gi == ZERO_ADDR) begin : g_zero
      registerNzero #(.WIDTH(WIDTH)) u_reg (
        .o_q (w_entry[gi])
      );
    end else begin : g_reg
      registerN #(.WIDTH(WIDTH)) u_reg (
        .clk   (clk),
        .rst_n (reset_n),
        .i_we  (w_wr_sel[gi]),
        .i_d   (bus.write_data),
        .o_q   (w_entry[gi])
      );
    end
  end

  // Claim is ORed in after the write clear, so a same-edge claim and write to
  // one register leaves it pending (the new producer takes over).
  assign w_pending_next = (r_pending & ~w_wr_sel) | w_claim_sel;

  // w_hitN: a real (non-zero) write lands on the address read this edge.
  assign w_hit1 = w_wr_sel[bus.read_addr1];
  assign w_hit2 = w_wr_sel[bus.read_addr2];

  assign w_rd1_next = (BYPASS && w_hit1) ? bus.write_data : w_entry[bus.read_addr1];
  assign w_rd2_next = (BYPASS && w_hit2) ? bus.write_data : w_entry[bus.read_addr2];

  // With bypass the read already carries the new value, so a completing write
  // clears busy unless a claim on the same address re-arms it.
  assign w_busy1_next = BYPASS
    ? ((r_pending[bus.read_addr1] & ~w_hit1) | (w_hit1 & w_claim_sel[bus.read_addr1]))
    : r_pending[bus.read_addr1];
  assign w_busy2_next = BYPASS
    ? ((r_pending[bus.read_addr2] & ~w_hit2) | (w_hit2 & w_claim_sel[bus.read_addr2]))
    : r_pending[bus.read_addr2];

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pending    <= '0;
      r_read_data1 <= '0;
      r_read_data2 <= '0;
      r_busy1      <= 1'b0;
      r_busy2      <= 1'b0;
    end else begin
      r_pending    <= w_pending_next;
      r_read_data1 <= w_rd1_next;
      r_read_data2 <= w_rd2_next;
      r_busy1      <= w_busy1_next;
      r_busy2      <= w_busy2_next;
    end
  end

  assign bus.read_data1 = r_read_data1;
  assign bus.read_data2 = r_read_data2;
  assign bus.busy1      = r_busy1;
  assign bus.busy2      = r_busy2;

endmodule : regfile_2r1w

// File: tb/tb_regfile_2r1w.sv
// -----------------------------------------------------------------------------
// tb_regfile_2r1w
// Drives one BYPASS=1 and one BYPASS=0 instance with identical stimulus from a
// vector table; expected outputs are queued at drive time and popped after
// the edge. Hand-written sequences cover asynchronous reset behaviour.
// -----------------------------------------------------------------------------
module tb_regfile_2r1w;
  import regfile_pkg::*;

  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  regfile_2r1w_if #(.WIDTH(32), .ADDR_WIDTH(5)) bus1 ();
  regfile_2r1w_if #(.WIDTH(32), .ADDR_WIDTH(5)) bus0 ();

  regfile_2r1w #(.WIDTH(32), .ADDR_WIDTH(5), .BYPASS(1'b1)) u_dut_byp (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus1.slave)
  );

  regfile_2r1w #(.WIDTH(32), .ADDR_WIDTH(5), .BYPASS(1'b0)) u_dut_nobyp (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus0.slave)
  );

  typedef struct {
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        b1;
    logic        b2;
  } exp_t;

  typedef struct {
    logic        we;
    reg_addr_t   wa;
    logic [31:0] wd;
    reg_addr_t   ra1;
    reg_addr_t   ra2;
    logic        cl;
    reg_addr_t   ca;
    exp_t        e1;   // BYPASS=1 expectation
    exp_t        e0;   // BYPASS=0 expectation
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t q1[$];
  exp_t q0[$];
  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input reg_addr_t wa, input logic [31:0] wd,
                       input reg_addr_t ra1, input reg_addr_t ra2,
                       input logic cl, input reg_addr_t ca);
    bus1.wrenable = we;  bus0.wrenable = we;
    bus1.write_addr = wa; bus0.write_addr = wa;
    bus1.write_data = wd; bus0.write_data = wd;
    bus1.read_addr1 = ra1; bus0.read_addr1 = ra1;
    bus1.read_addr2 = ra2; bus0.read_addr2 = ra2;
    bus1.claim = cl; bus0.claim = cl;
    bus1.claim_addr = ca; bus0.claim_addr = ca;
  endtask

  function automatic exp_t mk_e(input logic [31:0] rd1, input logic [31:0] rd2,
                                input logic b1, input logic b2);
    exp_t e;
    e.rd1 = rd1; e.rd2 = rd2; e.b1 = b1; e.b2 = b2;
    return e;
  endfunction

  function automatic vec_t mk_v(input logic we, input int wa, input logic [31:0] wd,
                                input int ra1, input int ra2, input logic cl, input int ca,
                                input exp_t e1, input exp_t e0);
    vec_t v;
    v.we = we; v.wa = reg_addr_t'(wa); v.wd = wd;
    v.ra1 = reg_addr_t'(ra1); v.ra2 = reg_addr_t'(ra2);
    v.cl = cl; v.ca = reg_addr_t'(ca);
    v.e1 = e1; v.e0 = e0;
    return v;
  endfunction

  // Drive at the falling edge, queue expectations, compare #1 after the
  // rising edge that samples them.
  task automatic step(input string tag, input vec_t v);
    exp_t a1, a0;
    @(negedge clk);
    drive(v.we, v.wa, v.wd, v.ra1, v.ra2, v.cl, v.ca);
    q1.push_back(v.e1);
    q0.push_back(v.e0);
    @(posedge clk);
    #1;
    a1 = q1.pop_front();
    a0 = q0.pop_front();
    check({tag, "_byp_rd1"},   bus1.read_data1, a1.rd1);
    check({tag, "_byp_rd2"},   bus1.read_data2, a1.rd2);
    check({tag, "_byp_b1"},    32'(bus1.busy1), 32'(a1.b1));
    check({tag, "_byp_b2"},    32'(bus1.busy2), 32'(a1.b2));
    check({tag, "_nobyp_rd1"}, bus0.read_data1, a0.rd1);
    check({tag, "_nobyp_rd2"}, bus0.read_data2, a0.rd2);
    check({tag, "_nobyp_b1"},  32'(bus0.busy1), 32'(a0.b1));
    check({tag, "_nobyp_b2"},  32'(bus0.busy2), 32'(a0.b2));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_byp_rd1"},   bus1.read_data1, 32'h0);
    check({tag, "_byp_rd2"},   bus1.read_data2, 32'h0);
    check({tag, "_byp_busy"},  32'({bus1.busy1, bus1.busy2}), 32'h0);
    check({tag, "_nobyp_rd1"}, bus0.read_data1, 32'h0);
    check({tag, "_nobyp_rd2"}, bus0.read_data2, 32'h0);
    check({tag, "_nobyp_busy"}, 32'({bus0.busy1, bus0.busy2}), 32'h0);
  endtask

  initial begin
    exp_t z;
    z = mk_e(32'h0, 32'h0, 1'b0, 1'b0);

    //            we wa wd            ra1 ra2 cl ca   BYPASS=1                                      BYPASS=0
    vecs.push_back(mk_v(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, z, z));
    vecs.push_back(mk_v(0, 0, 32'h0,        5, 5, 0, 0, mk_e(32'hDEADBEEF, 32'hDEADBEEF, 0, 0), mk_e(32'hDEADBEEF, 32'hDEADBEEF, 0, 0)));
    vecs.push_back(mk_v(1, 0, 32'h1234,     0, 5, 0, 0, mk_e(32'h0, 32'hDEADBEEF, 0, 0),        mk_e(32'h0, 32'hDEADBEEF, 0, 0)));
    vecs.push_back(mk_v(0, 0, 32'h0,        0, 0, 0, 0, z, z));
    vecs.push_back(mk_v(1, 7, 32'hA5A5A5A5, 7, 7, 0, 0, mk_e(32'hA5A5A5A5, 32'hA5A5A5A5, 0, 0), z));
    vecs.push_back(mk_v(0, 0, 32'h0,        7, 7, 0, 0, mk_e(32'hA5A5A5A5, 32'hA5A5A5A5, 0, 0), mk_e(32'hA5A5A5A5, 32'hA5A5A5A5, 0, 0)));
    vecs.push_back(mk_v(0, 0, 32'h0,        7, 0, 1, 3, mk_e(32'hA5A5A5A5, 32'h0, 0, 0),        mk_e(32'hA5A5A5A5, 32'h0, 0, 0)));
    vecs.push_back(mk_v(0, 0, 32'h0,        5, 3, 0, 0, mk_e(32'hDEADBEEF, 32'h0, 0, 1),        mk_e(32'hDEADBEEF, 32'h0, 0, 1)));
    vecs.push_back(mk_v(1, 3, 32'h33,       3, 3, 0, 0, mk_e(32'h33, 32'h33, 0, 0),             mk_e(32'h0, 32'h0, 1, 1)));
    vecs.push_back(mk_v(0, 0, 32'h0,        3, 3, 0, 0, mk_e(32'h33, 32'h33, 0, 0),             mk_e(32'h33, 32'h33, 0, 0)));
    vecs.push_back(mk_v(0, 0, 32'h0,        0, 0, 1, 0, z, z));
    vecs.push_back(mk_v(0, 0, 32'h0,        0, 0, 0, 0, z, z));
    vecs.push_back(mk_v(1, 9, 32'h99,       9, 0, 1, 9, mk_e(32'h99, 32'h0, 1, 0),              z));
    vecs.push_back(mk_v(0, 0, 32'h0,        9, 9, 0, 0, mk_e(32'h99, 32'h99, 1, 1),             mk_e(32'h99, 32'h99, 1, 1)));
    vecs.push_back(mk_v(1, 6, 32'h66,       4, 6, 1, 4, mk_e(32'h0, 32'h66, 0, 0),              z));
    vecs.push_back(mk_v(0, 0, 32'h0,        4, 6, 0, 0, mk_e(32'h0, 32'h66, 1, 0),              mk_e(32'h0, 32'h66, 1, 0)));
    vecs.push_back(mk_v(1, 4, 32'h44,       4, 9, 0, 0, mk_e(32'h44, 32'h99, 0, 1),             mk_e(32'h0, 32'h99, 1, 1)));

    // Power-up reset: outputs must be zero without any clock edge.
    drive(1'b0, '0, 32'h0, '0, '0, 1'b0, '0);
    reset_n = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("por_async");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    foreach (vecs[i]) step($sformatf("v%0d", i), vecs[i]);

    // Mid-operation reset: claim+write r2, then reset in the middle of a cycle.
    step("mid_claim", mk_v(1, 2, 32'h55, 2, 2, 1, 2, mk_e(32'h55, 32'h55, 1, 1), z));
    @(negedge clk);
    drive(1'b1, 5'd2, 32'h77, 5'd2, 5'd5, 1'b1, 5'd2);
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("mid_async");
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("mid_held");
    @(negedge clk);
    drive(1'b0, '0, 32'h0, '0, '0, 1'b0, '0);
    reset_n = 1'b1;

    step("post_r2_r5", mk_v(0, 0, 32'h0, 2, 5, 0, 0, z, z));
    step("post_r9_r4", mk_v(0, 0, 32'h0, 9, 4, 0, 0, z, z));
    step("post_r7_r3", mk_v(0, 0, 32'h0, 7, 3, 0, 0, z, z));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_regfile_2r1w
